// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants and types for the seven-segment scanner.
//   SEG_BLANK : segment pattern with every segment dark (active-low bus).
//   AN_OFF    : widest digit-enable pattern with every digit off; slice to N_DIGITS.
//   BCD_BLANK : decoder input code that draws nothing (used for zero suppression).
//   state_t   : slot phase, ST_BLANK (dead-time) or ST_DRIVE (digit lit).
package seven_segment_scanner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] AN_OFF    = 8'hFF;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// BCD to seven-segment decoder for the common-anode display bank.
// Ports:
//   digit : 4-bit BCD code; 10..15 draw a blank digit.
//   seg   : segments g..a, active-low.
module seven_segment
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Code-to-segment lookup; anything outside 0..9 stays dark.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a common-anode seven-segment bank.
// Each digit gets a slot of REFRESH_DIV cycles; the first BLANK_CYC cycles of
// every slot are dead-time with all digits off. The displayed value is double
// buffered: loads land in a pending register and move to the shadow register
// only at the frame boundary (the edge on which the digit index wraps to 0).
// Ports:
//   clk        : system clock.
//   reset      : synchronous, active-high reset.
//   value_in   : BCD digits, digit 0 in bits [3:0] (rightmost).
//   load       : one-cycle strobe capturing value_in.
//   lz_en      : leading-zero suppression enable (level).
//   an         : digit enables, active-low, registered.
//   seg        : segments g..a, active-low, registered.
//   frame_tick : one-cycle pulse in the first cycle of every new frame.
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST       = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF     = AN_OFF[N_DIGITS-1:0];

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*N_DIGITS-1:0]   shadow_r;
  logic [4*N_DIGITS-1:0]   pending_r;
  logic                    pending_valid_r;
  logic [N_DIGITS-1:0]     an_r;
  logic [6:0]              seg_r;
  logic                    frame_tick_r;

  state_t                  state_next_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic [IDX_W-1:0]        idx_next_s;
  logic [4*N_DIGITS-1:0]   shadow_next_s;
  logic [4*N_DIGITS-1:0]   pending_next_s;
  logic                    pending_valid_next_s;
  logic                    frame_wrap_s;
  logic [N_DIGITS-1:0]     supp_s;
  logic [3:0]              digit_sel_s;
  logic [3:0]              dec_in_s;
  logic [6:0]              dec_seg_s;
  logic [N_DIGITS-1:0]     an_next_s;
  logic [6:0]              seg_next_s;

  // Slot counter, digit index and dead-time/drive phase transitions.
  always_comb begin
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    frame_wrap_s = 1'b0;
    state_next_s = state_r;
    if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
      if (idx_r == IDX_LAST) begin
        idx_next_s   = '0;
        frame_wrap_s = 1'b1;
      end else begin
        idx_next_s = idx_r + IDX_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == CNT_BLANK_LAST) begin
          state_next_s = ST_DRIVE;
        end else begin
          state_next_s = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = ST_BLANK;
        end else begin
          state_next_s = ST_DRIVE;
        end
      end
      default: state_next_s = ST_BLANK;
    endcase
  end

  // Double buffer: a load on the boundary cycle goes straight to shadow,
  // otherwise it waits in pending (last load wins) until the next boundary.
  always_comb begin
    shadow_next_s        = shadow_r;
    pending_next_s       = pending_r;
    pending_valid_next_s = pending_valid_r;
    if (frame_wrap_s) begin
      if (load) begin
        shadow_next_s        = value_in;
        pending_valid_next_s = 1'b0;
      end else if (pending_valid_r) begin
        shadow_next_s        = pending_r;
        pending_valid_next_s = 1'b0;
      end else begin
        shadow_next_s = shadow_r;
      end
    end else begin
      if (load) begin
        pending_next_s       = value_in;
        pending_valid_next_s = 1'b1;
      end else begin
        pending_next_s = pending_r;
      end
    end
  end

  // Leading-zero suppression: blank zeros from the top digit down until the
  // first non-zero code; digit 0 is never suppressed.
  always_comb begin : lz_blk
    logic lead_v;
    supp_s = '0;
    lead_v = lz_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lead_v && (shadow_next_s[4*i +: 4] == 4'h0)) begin
        supp_s[i] = 1'b1;
      end else begin
        lead_v = 1'b0;
      end
    end
  end

  // Outputs are computed from next-state values so they change on the same
  // edge as the phase/index that selects them.
  always_comb begin
    digit_sel_s = shadow_next_s[{idx_next_s, 2'b00} +: 4];
    dec_in_s    = digit_sel_s;
    an_next_s   = AN_ALL_OFF;
    seg_next_s  = SEG_BLANK;
    if (supp_s[idx_next_s]) begin
      dec_in_s = BCD_BLANK;
    end else begin
      dec_in_s = digit_sel_s;
    end
    if (state_next_s == ST_DRIVE) begin
      an_next_s  = ~(N_DIGITS'(1) << idx_next_s);
      seg_next_s = dec_seg_s;
    end else begin
      an_next_s  = AN_ALL_OFF;
      seg_next_s = SEG_BLANK;
    end
  end

  seven_segment u_decoder (
    .digit (dec_in_s),
    .seg   (dec_seg_s)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_BLANK;
      cnt_r           <= '0;
      idx_r           <= '0;
      shadow_r        <= '0;
      pending_r       <= '0;
      pending_valid_r <= 1'b0;
      an_r            <= AN_ALL_OFF;
      seg_r           <= SEG_BLANK;
      frame_tick_r    <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      cnt_r           <= cnt_next_s;
      idx_r           <= idx_next_s;
      shadow_r        <= shadow_next_s;
      pending_r       <= pending_next_s;
      pending_valid_r <= pending_valid_next_s;
      an_r            <= an_next_s;
      seg_r           <= seg_next_s;
      frame_tick_r    <= frame_wrap_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign frame_tick = frame_tick_r;

endmodule
